cpu_memory: RTL and testbench

CPU_MEMORY -- requirements
Module: cpu_memory

---
 rtl/cpu_memory_if.sv | 39 +++
 rtl/cpu_memory.sv | 106 ++++++++++
 tb/tb_cpu_memory.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_memory_if.sv
`default_nettype none
// ============================================================================
// cpu_memory_if : CPU fetch/load/store and program-loader bus for cpu_memory
// Revision: 1.0
// ============================================================================
interface cpu_memory_if #(
   parameter int WIDTH_DATA = 32,
   parameter int AWIDTH     = 5,
   parameter int DAWIDTH    = 10
);
   logic [AWIDTH-1:0]     address_memory_inst;
   logic                  read_inst_enable;
   logic [WIDTH_DATA-1:0] instruction;
   logic [DAWIDTH-1:0]    address_memory_data;
   logic                  read_data_enable;
   logic                  write_data_enable;
   logic [WIDTH_DATA-1:0] memory_data_out;
   logic [WIDTH_DATA-1:0] memory_data_in;
   logic                  load_valid;
   logic [WIDTH_DATA-1:0] load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  run;

   modport master (
      output address_memory_inst, read_inst_enable,
      output address_memory_data, read_data_enable, write_data_enable, memory_data_out,
      output load_valid, load_data, load_last,
      input  instruction, memory_data_in, load_ready, run
   );

   modport slave (
      input  address_memory_inst, read_inst_enable,
      input  address_memory_data, read_data_enable, write_data_enable, memory_data_out,
      input  load_valid, load_data, load_last,
      output instruction, memory_data_in, load_ready, run
   );
endinterface
`default_nettype wire

// File: rtl/cpu_memory.sv
`default_nettype none
// ============================================================================
// cpu_memory : program-loaded instruction memory plus data memory for a CPU
// Revision: 1.0
// ============================================================================
module cpu_memory #(
   parameter int WIDTH_DATA = 32,
   parameter int AWIDTH     = 5,
   parameter int DAWIDTH    = 10
) (
   input  logic        clk,
   input  logic        reset,
   cpu_memory_if.slave bus
);
   localparam int IMEM_DEPTH = 1 << AWIDTH;
   localparam int DMEM_DEPTH = 1 << DAWIDTH;
   localparam logic [AWIDTH-1:0] PTR_ONE  = 1;
   localparam logic [AWIDTH-1:0] PTR_LAST = '1;
   localparam logic [AWIDTH:0]   CNT_ONE  = 1;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [AWIDTH-1:0]     ptr_q, ptr_d;
   logic [AWIDTH:0]       cnt_q, cnt_d;
   logic [WIDTH_DATA-1:0] instruction_q, instruction_d;
   logic [WIDTH_DATA-1:0] memory_data_in_q, memory_data_in_d;
   logic                  imem_we;
   logic                  dmem_we;

   logic [WIDTH_DATA-1:0] imem [IMEM_DEPTH];
   logic [WIDTH_DATA-1:0] dmem [DMEM_DEPTH];

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      cnt_d            = cnt_q;
      instruction_d    = instruction_q;
      memory_data_in_d = memory_data_in_q;
      imem_we          = 1'b0;
      dmem_we          = 1'b0;
      case (state_q)
         ST_LOAD: begin
            // load_ready is 1 throughout LOAD, so load_valid alone is an accept
            if (bus.load_valid) begin
               imem_we = 1'b1;
               ptr_d   = ptr_q + PTR_ONE;
               cnt_d   = cnt_q + CNT_ONE;
               if (bus.load_last || (ptr_q == PTR_LAST)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // Words at or beyond the loaded count read as NOP since imem is never cleared
            if (bus.read_inst_enable) begin
               instruction_d = ({1'b0, bus.address_memory_inst} < cnt_q)
                             ? imem[bus.address_memory_inst] : '0;
            end
            if (bus.read_data_enable) begin
               memory_data_in_d = dmem[bus.address_memory_data];
            end
            dmem_we = bus.write_data_enable;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_LOAD;
         ptr_q            <= '0;
         cnt_q            <= '0;
         instruction_q    <= '0;
         memory_data_in_q <= '0;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         cnt_q            <= cnt_d;
         instruction_q    <= instruction_d;
         memory_data_in_q <= memory_data_in_d;
      end
   end

   // Read-first: the load above samples dmem before this edge's store lands
   always_ff @(posedge clk) begin
      if (!reset && imem_we) begin
         imem[ptr_q] <= bus.load_data;
      end
      if (!reset && dmem_we) begin
         dmem[bus.address_memory_data] <= bus.memory_data_out;
      end
   end

   assign bus.instruction    = instruction_q;
   assign bus.memory_data_in = memory_data_in_q;
   assign bus.load_ready     = (state_q == ST_LOAD);
   assign bus.run            = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory.sv
`default_nettype none
// ============================================================================
// tb_cpu_memory : directed vector bench for cpu_memory
// Revision: 1.0
// ============================================================================
module tb_cpu_memory;
   logic clk;
   logic reset;
   int   total;
   int   passed;

   cpu_memory_if #(.WIDTH_DATA(32), .AWIDTH(5), .DAWIDTH(10)) bus ();

   cpu_memory #(.WIDTH_DATA(32), .AWIDTH(5), .DAWIDTH(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rie;
      logic [4:0]  ia;
      logic        rde;
      logic        wde;
      logic [9:0]  da;
      logic [31:0] wd;
      logic        lv;
      logic [31:0] ld;
      logic [31:0] exp_instr;
      logic [31:0] exp_mdi;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
      total++;
      if (act !== bad) passed++;
      else $display("FAIL %s: got 0x%08h which must differ from 0x%08h", name, act, bad);
   endtask

   task automatic drive(input logic rst, input logic lv, input logic ll, input logic [31:0] ld,
                        input logic rie, input logic [4:0] ia, input logic rde, input logic wde,
                        input logic [9:0] da, input logic [31:0] wd);
      @(negedge clk);
      reset                   = rst;
      bus.load_valid          = lv;
      bus.load_last           = ll;
      bus.load_data           = ld;
      bus.read_inst_enable    = rie;
      bus.address_memory_inst = ia;
      bus.read_data_enable    = rde;
      bus.write_data_enable   = wde;
      bus.address_memory_data = da;
      bus.memory_data_out     = wd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b1;
      bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.load_data = '0;
      bus.read_inst_enable = 1'b0; bus.address_memory_inst = '0;
      bus.read_data_enable = 1'b0; bus.write_data_enable = 1'b0;
      bus.address_memory_data = '0; bus.memory_data_out = '0;

      // Reset state
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
      chk("rst_run", 32'(bus.run), 32'd0);
      chk("rst_instr", bus.instruction, 32'h0);
      chk("rst_mdi", bus.memory_data_in, 32'h0);

      // Three-word load with CPU strobes that must be ignored in LOAD
      drive(0, 1, 0, 32'h11, 1, 5'd0, 1, 1, 10'd7, 32'h55);
      chk("load1_run", 32'(bus.run), 32'd0);
      chk("load1_instr", bus.instruction, 32'h0);
      chk("load1_mdi", bus.memory_data_in, 32'h0);
      drive(0, 0, 0, 32'h99, 1, 5'd0, 0, 1, 10'd7, 32'h55);
      chk("idle_ready", 32'(bus.load_ready), 32'd1);
      chk("idle_run", 32'(bus.run), 32'd0);
      drive(0, 1, 0, 32'h22, 0, 5'd0, 0, 0, 10'd0, 32'h0);
      chk("load2_run", 32'(bus.run), 32'd0);
      drive(0, 1, 1, 32'h33, 0, 5'd0, 0, 0, 10'd0, 32'h0);
      chk("load3_run", 32'(bus.run), 32'd1);
      chk("load3_ready", 32'(bus.load_ready), 32'd0);

      // The LOAD-phase store to address 7 must not have landed
      drive(0, 0, 0, 0, 0, 5'd0, 1, 0, 10'd7, 32'h0);
      chk_ne("dmem7_not_55", bus.memory_data_in, 32'h55);
      drive(0, 0, 0, 0, 0, 5'd0, 0, 1, 10'd7, 32'h70);
      drive(0, 0, 0, 0, 0, 5'd0, 1, 0, 10'd7, 32'h0);
      chk("dmem7_rd", bus.memory_data_in, 32'h70);

      //          rie  ia    rde  wde  da       wd            lv   ld          instr        mdi
      vecs[0]  = '{1'b1, 5'd0, 1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 32'h0,  32'h11,      32'h70};
      vecs[1]  = '{1'b1, 5'd1, 1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 32'h0,  32'h22,      32'h70};
      vecs[2]  = '{1'b1, 5'd2, 1'b0, 1'b0, 10'd0,   32'h0,        1'b1, 32'hEE, 32'h33,      32'h70};
      vecs[3]  = '{1'b1, 5'd3, 1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 32'h0,  32'h0,       32'h70};
      vecs[4]  = '{1'b1, 5'd1, 1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 32'h0,  32'h22,      32'h70};
      vecs[5]  = '{1'b0, 5'd2, 1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 32'h0,  32'h22,      32'h70};
      vecs[6]  = '{1'b0, 5'd0, 1'b0, 1'b1, 10'h3FF, 32'hDEADBEEF, 1'b0, 32'h0,  32'h22,      32'h70};
      vecs[7]  = '{1'b0, 5'd0, 1'b1, 1'b0, 10'h3FF, 32'h0,        1'b0, 32'h0,  32'h22,      32'hDEADBEEF};
      vecs[8]  = '{1'b0, 5'd0, 1'b0, 1'b1, 10'd5,   32'hA,        1'b0, 32'h0,  32'h22,      32'hDEADBEEF};
      vecs[9]  = '{1'b0, 5'd0, 1'b1, 1'b1, 10'd5,   32'hB,        1'b0, 32'h0,  32'h22,      32'hA};
      vecs[10] = '{1'b0, 5'd0, 1'b1, 1'b0, 10'd5,   32'h0,        1'b0, 32'h0,  32'h22,      32'hB};
      vecs[11] = '{1'b1, 5'd0, 1'b1, 1'b0, 10'h3FF, 32'h0,        1'b0, 32'h0,  32'h11,      32'hDEADBEEF};
      vecs[12] = '{1'b1, 5'd3, 1'b0, 1'b0, 10'd5,   32'h0,        1'b0, 32'h0,  32'h0,       32'hDEADBEEF};

      for (int i = 0; i < 13; i++) begin
         drive(0, vecs[i].lv, 1'b0, vecs[i].ld, vecs[i].rie, vecs[i].ia,
               vecs[i].rde, vecs[i].wde, vecs[i].da, vecs[i].wd);
         chk($sformatf("vec%0d_instr", i), bus.instruction, vecs[i].exp_instr);
         chk($sformatf("vec%0d_mdi", i), bus.memory_data_in, vecs[i].exp_mdi);
         chk($sformatf("vec%0d_run", i), 32'(bus.run), 32'd1);
      end

      // Full 32-word load without load_last
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         drive(0, 1, 0, 32'h100 + 32'(i), 0, 5'd0, 0, 0, 10'd0, 32'h0);
         if (i == 30) chk("full_w30_run", 32'(bus.run), 32'd0);
      end
      chk("full_run", 32'(bus.run), 32'd1);
      chk("full_ready", 32'(bus.load_ready), 32'd0);
      drive(0, 1, 0, 32'hBAD, 0, 5'd0, 0, 0, 10'd0, 32'h0);
      chk("extra_word_run", 32'(bus.run), 32'd1);
      drive(0, 0, 0, 0, 1, 5'd0, 0, 0, 10'd0, 32'h0);
      chk("full_fetch0", bus.instruction, 32'h100);
      drive(0, 0, 0, 0, 1, 5'd31, 0, 0, 10'd0, 32'h0);
      chk("full_fetch31", bus.instruction, 32'h11F);

      // Reset in RUN after a 4-word load, then a 1-word reload
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, (i == 3), 32'hA0 + 32'(i), 0, 5'd0, 0, 0, 10'd0, 32'h0);
      end
      chk("four_run", 32'(bus.run), 32'd1);
      drive(0, 0, 0, 0, 1, 5'd2, 0, 0, 10'd0, 32'h0);
      chk("four_fetch2", bus.instruction, 32'hA2);
      drive(1, 1, 0, 32'h55, 1, 5'd2, 0, 1, 10'h3FF, 32'h12345678);
      chk("midrst_run", 32'(bus.run), 32'd0);
      chk("midrst_ready", 32'(bus.load_ready), 32'd1);
      chk("midrst_instr", bus.instruction, 32'h0);
      drive(0, 1, 1, 32'h77, 0, 5'd0, 0, 0, 10'd0, 32'h0);
      chk("reload_run", 32'(bus.run), 32'd1);
      drive(0, 0, 0, 0, 1, 5'd1, 0, 0, 10'd0, 32'h0);
      chk("reload_fetch1", bus.instruction, 32'h0);
      drive(0, 0, 0, 0, 1, 5'd0, 0, 0, 10'd0, 32'h0);
      chk("reload_fetch0", bus.instruction, 32'h77);
      drive(0, 0, 0, 0, 0, 5'd0, 1, 0, 10'h3FF, 32'h0);
      chk("rst_store_blocked", bus.memory_data_in, 32'hDEADBEEF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire
